// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan code set 2 sequencer: pops FIFO bytes, folds E0/F0/E1 prefixes into key events.
// Optional typematic repeat filter: define PS2_KBD_CTRL_TYPEMATIC_FILTER_EN.
module ps2_kbd_ctrl #(
    parameter int unsigned PREFIX_TIMEOUT = 2500000,
    parameter int unsigned CNT_W          = 22
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] kb_data,
    input  logic       kb_ready,
    input  logic       kb_overflow,
    output logic       kb_rdn,
    output logic       ev_valid,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_brk,
    input  logic       ev_ack,
    output logic       mod_shift,
    output logic       mod_ctrl,
    output logic       mod_alt,
    output logic       err_ovf,
    input  logic       err_clr
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_DECODE = 3'd2,
        S_SKIP   = 3'd3,
        S_EMIT   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(PREFIX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [7:0]       byte_q;
    logic             ext_p_q;
    logic             brk_p_q;
    logic [2:0]       skip_cnt_q;
    logic [CNT_W-1:0] tmo_cnt_q;

    logic       is_ctrl_byte;
    logic       pending;
    logic [2:0] skip_dec;
    logic       drop_repeat;

    // Receive-only bytes (ack, BAT, echo, resend...) that never form a key event
    always_comb begin
        case (byte_q)
            8'h00, 8'hAA, 8'hEE, 8'hFA,
            8'hFC, 8'hFD, 8'hFE, 8'hFF: is_ctrl_byte = 1'b1;
            default:                    is_ctrl_byte = 1'b0;
        endcase
    end

    assign pending  = ext_p_q | brk_p_q | (skip_cnt_q != 3'd0);
    assign skip_dec = skip_cnt_q - 3'd1;

`ifdef PS2_KBD_CTRL_TYPEMATIC_FILTER_EN
    logic [8:0] last_make_q;
    logic       held_q;
    logic       make_match;

    assign make_match  = (last_make_q == {ext_p_q, byte_q});
    assign drop_repeat = ~brk_p_q & held_q & make_match;

    // Remembers the most recent make so auto-repeats of a held key can be suppressed
    always_ff @(posedge clk) begin
        if (clr) begin
            last_make_q <= 9'd0;
            held_q      <= 1'b0;
        end else if (state_q == S_DECODE && byte_q != 8'hE0 && byte_q != 8'hF0 &&
                     byte_q != 8'hE1 && !(is_ctrl_byte && !brk_p_q) && !drop_repeat) begin
            if (brk_p_q) begin
                if (make_match) begin
                    held_q <= 1'b0;
                end
            end else begin
                last_make_q <= {ext_p_q, byte_q};
                held_q      <= 1'b1;
            end
        end
    end
`else
    assign drop_repeat = 1'b0;
`endif

    // Main sequencer: FIFO handshake, prefix decoding, event emission, prefix timeout
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            byte_q     <= 8'd0;
            ext_p_q    <= 1'b0;
            brk_p_q    <= 1'b0;
            skip_cnt_q <= 3'd0;
            tmo_cnt_q  <= CNT_ZERO;
            kb_rdn     <= 1'b1;
            ev_valid   <= 1'b0;
            ev_code    <= 8'd0;
            ev_ext     <= 1'b0;
            ev_brk     <= 1'b0;
            mod_shift  <= 1'b0;
            mod_ctrl   <= 1'b0;
            mod_alt    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (kb_ready) begin
                        byte_q    <= kb_data;
                        kb_rdn    <= 1'b0;
                        tmo_cnt_q <= CNT_ZERO;
                        state_q   <= S_POP;
                    end else if (pending) begin
                        // A lone prefix whose follow-up never arrives is silently dropped
                        if (tmo_cnt_q == TMO_LAST) begin
                            ext_p_q    <= 1'b0;
                            brk_p_q    <= 1'b0;
                            skip_cnt_q <= 3'd0;
                            tmo_cnt_q  <= CNT_ZERO;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + CNT_ONE;
                        end
                    end else begin
                        tmo_cnt_q <= CNT_ZERO;
                    end
                end
                S_POP: begin
                    kb_rdn  <= 1'b1;
                    state_q <= (skip_cnt_q != 3'd0) ? S_SKIP : S_DECODE;
                end
                S_DECODE: begin
                    state_q <= S_IDLE;
                    if (byte_q == 8'hE0) begin
                        ext_p_q <= 1'b1;
                    end else if (byte_q == 8'hF0) begin
                        brk_p_q <= 1'b1;
                    end else if (byte_q == 8'hE1) begin
                        skip_cnt_q <= 3'd7;
                    end else begin
                        ext_p_q <= 1'b0;
                        brk_p_q <= 1'b0;
                        if (!(is_ctrl_byte && !brk_p_q) && !drop_repeat) begin
                            ev_code  <= byte_q;
                            ev_ext   <= ext_p_q;
                            ev_brk   <= brk_p_q;
                            ev_valid <= 1'b1;
                            state_q  <= S_EMIT;
                            if (!ext_p_q && (byte_q == 8'h12 || byte_q == 8'h59)) begin
                                mod_shift <= ~brk_p_q;
                            end
                            if (byte_q == 8'h14) begin
                                mod_ctrl <= ~brk_p_q;
                            end
                            if (byte_q == 8'h11) begin
                                mod_alt <= ~brk_p_q;
                            end
                        end
                    end
                end
                S_SKIP: begin
                    // The 8-byte pause sequence has no break and collapses into one E0-77 make
                    skip_cnt_q <= skip_dec;
                    if (skip_dec == 3'd0) begin
                        ev_code  <= 8'h77;
                        ev_ext   <= 1'b1;
                        ev_brk   <= 1'b0;
                        ev_valid <= 1'b1;
                        state_q  <= S_EMIT;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_EMIT: begin
                    if (ev_ack) begin
                        ev_valid <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    kb_rdn   <= 1'b1;
                    ev_valid <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow flag; a simultaneous overflow outranks the clear
    always_ff @(posedge clk) begin
        if (clr) begin
            err_ovf <= 1'b0;
        end else if (kb_overflow) begin
            err_ovf <= 1'b1;
        end else if (err_clr) begin
            err_ovf <= 1'b0;
        end
    end

endmodule
